gobackn_receiver: RTL
=====================

Name: gobackn_receiver

Overview:
- Receive end of the Go-Back-N link, facing the gobackn sender.
- Accepts sequence-numbered frames.
- Delivers only the in-order frames downstream over a valid/ready port.
- Discards corrupted and out-of-order frames.
- Returns a cumulative ACK (next expected sequence number) toward the sender.
- Keeps saturating accept/drop statistics for link diagnostics.

Parameters:
- DATA_WIDTH, 8, width of the frame payload.
- SEQ_WIDTH, 3, sequence-number width; sequence space is 2^SEQ_WIDTH, arithmetic is modulo 2^SEQ_WIDTH.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- frm_valid  input  1  incoming frame present.
- frm_ready  output  1  receiver can take a frame this cycle.
- frm_seq  input  SEQ_WIDTH  frame sequence number.
- frm_data  input  DATA_WIDTH  frame payload.
- frm_err  input  1  link flagged frame as corrupted (checksum fail).
- out_valid  output  1  in-order payload available downstream.
- out_ready  input  1  downstream accepts payload.
- out_data  output  DATA_WIDTH  delivered payload.
- ack_valid  output  1  ACK available to the return channel.
- ack_ready  input  1  return channel accepts ACK.
- ack_num  output  SEQ_WIDTH  cumulative ACK value = next expected sequence number.
- expected_seq  output  SEQ_WIDTH  current next-expected sequence number.
- cnt_accepted  output  CNT_WIDTH  frames delivered in order.
- cnt_dropped  output  CNT_WIDTH  frames discarded (corrupt or out of order).

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - state=IDLE.
  - frm_ready=1 from the first cycle after reset; otherwise follows state.
  - out_valid=0, out_data=0, ack_valid=0, ack_num=0, expected_seq=0, both counters=0.
  - Reset mid-operation abandons any pending out/ack handshake without completing it.
- Frame accept: a frame is taken on an edge where frm_valid && frm_ready. The receiver registers frm_seq, frm_data and frm_err at that edge.
- FSM states are IDLE, EVAL, DELIVER, ACK.
- IDLE:
  - frm_ready=1, all other valids 0.
  - On accept, go to EVAL.
- EVAL (one cycle, frm_ready=0). Three cases:
  - frm_err=1: drop silently. cnt_dropped+1, expected_seq unchanged, no ACK sent (sender recovers by timeout). Next state IDLE.
  - else seq==expected_seq: load out_data, out_valid<=1, expected_seq<=expected_seq+1 (wraps 2^SEQ_WIDTH-1 to 0), cnt_accepted+1. Next state DELIVER.
  - else (out of order or duplicate): drop. cnt_dropped+1, ack_num<=expected_seq, ack_valid<=1. Next state ACK (duplicate ACK triggers sender go-back).
- DELIVER:
  - out_valid and out_data held stable until out_ready.
  - On out_valid && out_ready: out_valid<=0, ack_num<=expected_seq (already incremented), ack_valid<=1. Next state ACK.
- ACK:
  - ack_valid and ack_num held stable until ack_ready.
  - On handshake: ack_valid<=0. Next state IDLE.
- Latency with no backpressure:
  - Accept edge T → out_valid high in the cycle after EVAL (2 cycles after accept).
  - ack_valid 1 cycle after the out handshake.
  - frm_ready low from accept until ACK (or drop) completes.
  - Minimum throughput: 1 frame per 4 cycles for in-order frames, 3 cycles for out-of-order, 2 cycles for corrupt.
- Only one frame is in flight. No payload buffering beyond the out_data register.
- Counters saturate at all-ones; they never wrap.
- expected_seq changes only in EVAL on an in-order, error-free frame.

Test Plan:
- Reset: hold rst 2 cycles → all outputs 0, expected_seq=0. Release → frm_ready=1 in the following cycle.
- In-order with wrap: seq 0..9 (mod 8), data 0xA0+i, out_ready=ack_ready=1.
  - out_data sequence is 0xA0..0xA9.
  - ack_num sequence is 1,2,...,7,0,1,2.
  - cnt_accepted=10, cnt_dropped=0.
- Out-of-order: accept seq0, then send seq2 (data 0x55).
  - For seq2: no out_valid, ack_num=1, cnt_dropped=1, expected_seq stays 1.
  - Then send seq1 → delivered, ack_num=2.
- Corrupt frame: expected_seq=3, send seq3 with frm_err=1 → no out_valid, no ack_valid, cnt_dropped+1, expected_seq=3.
- Backpressure: out_ready low 5 cycles during DELIVER.
  - out_valid and out_data stable, frm_ready=0, ack_valid=0 throughout.
  - After the out handshake, hold ack_ready low 3 cycles → ack_num stable, then IDLE after the ACK handshake.
- Reset mid-DELIVER: assert rst while out_valid=1.
  - Next cycle: out_valid=0, expected_seq=0, counters=0, frm_ready=1 after release.
  - Saturation variant: force cnt_dropped to 0xFFFF, drop another frame → stays 0xFFFF.

Source files
------------

// File: rtl/gobackn_receiver_if.sv
// gobackn_receiver_if: frame, delivery, ACK and status signals of the Go-Back-N receiver
// master drives frames and downstream/return-channel readies, slave is the receiver
interface gobackn_receiver_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEQ_WIDTH  = 3,
    parameter int CNT_WIDTH  = 16
);
    logic                  frm_valid;
    logic                  frm_ready;
    logic [SEQ_WIDTH-1:0]  frm_seq;
    logic [DATA_WIDTH-1:0] frm_data;
    logic                  frm_err;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  ack_valid;
    logic                  ack_ready;
    logic [SEQ_WIDTH-1:0]  ack_num;
    logic [SEQ_WIDTH-1:0]  expected_seq;
    logic [CNT_WIDTH-1:0]  cnt_accepted;
    logic [CNT_WIDTH-1:0]  cnt_dropped;
    modport master (
        output frm_valid, frm_seq, frm_data, frm_err, out_ready, ack_ready,
        input  frm_ready, out_valid, out_data, ack_valid, ack_num, expected_seq,
               cnt_accepted, cnt_dropped
    );
    modport slave (
        input  frm_valid, frm_seq, frm_data, frm_err, out_ready, ack_ready,
        output frm_ready, out_valid, out_data, ack_valid, ack_num, expected_seq,
               cnt_accepted, cnt_dropped
    );
endinterface

// File: rtl/gobackn_receiver.sv
// gobackn_receiver: Go-Back-N receive end delivering in-order frames and returning cumulative ACKs
// ports: clk, rst (sync active-high); bus.frm_* frame input, bus.out_* downstream payload,
// bus.ack_* cumulative ACK, bus.expected_seq next expected seq, bus.cnt_* saturating statistics
module gobackn_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int SEQ_WIDTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    gobackn_receiver_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EVAL, DELIVER, ACK} state_t;
    state_t                state, state_n;
    logic [SEQ_WIDTH-1:0]  seq_r, exp_seq, ack_num;
    logic [DATA_WIDTH-1:0] data_r, out_data;
    logic                  err_r, out_valid, ack_valid, in_order;
    logic [CNT_WIDTH-1:0]  cnt_acc, cnt_drp;
    assign in_order         = !err_r && seq_r == exp_seq;
    assign bus.frm_ready    = state == IDLE;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = out_data;
    assign bus.ack_valid    = ack_valid;
    assign bus.ack_num      = ack_num;
    assign bus.expected_seq = exp_seq;
    assign bus.cnt_accepted = cnt_acc;
    assign bus.cnt_dropped  = cnt_drp;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.frm_valid ? EVAL : IDLE;
            EVAL:    state_n = err_r ? IDLE : in_order ? DELIVER : ACK;
            DELIVER: state_n = bus.out_ready ? ACK : DELIVER;
            ACK:     state_n = bus.ack_ready ? IDLE : ACK;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            seq_r     <= '0;
            data_r    <= '0;
            err_r     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ack_valid <= 1'b0;
            ack_num   <= '0;
            exp_seq   <= '0;
            cnt_acc   <= '0;
            cnt_drp   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.frm_valid) begin
                seq_r  <= bus.frm_seq;
                data_r <= bus.frm_data;
                err_r  <= bus.frm_err;
            end
            if (state == EVAL) begin
                if (in_order) begin
                    out_data  <= data_r;
                    out_valid <= 1'b1;
                    exp_seq   <= exp_seq + 1'b1;
                    cnt_acc   <= cnt_acc + CNT_WIDTH'(!(&cnt_acc));
                end else begin
                    // corrupt frames stay silent; out-of-order ones re-ACK to force a go-back
                    cnt_drp   <= cnt_drp + CNT_WIDTH'(!(&cnt_drp));
                    ack_num   <= exp_seq;
                    ack_valid <= !err_r;
                end
            end
            if (state == DELIVER && bus.out_ready) begin
                out_valid <= 1'b0;
                ack_num   <= exp_seq;
                ack_valid <= 1'b1;
            end
            if (state == ACK && bus.ack_ready)
                ack_valid <= 1'b0;
        end
    end
endmodule
